// File: rtl/chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem_arbiter
// Description : Round-robin arbiter sharing port A of the CHIP-8 unified
//               memory BRAM between the processor, the video engine and the
//               debug port. Each accepted request is translated into the flat
//               BRAM map (RAM 0..4095, VRAM 4096..4351, REG 4352..4374,
//               STK 4375..4406), issued one cycle later, and read data is
//               returned tagged to its requester after RD_LATENCY more cycles.
// Ports       : clk_in / rst_n_in          clock, async active-low reset
//               proc_*                     processor request (region + offset)
//               video_*                    video request (VRAM byte offset)
//               dbg_*                      debug request (raw flat address)
//               mem_*                      BRAM port-A interface
//               rdata_out, *_rvalid_out    tagged read return
//               err_out                    pulse when an illegal request drops
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_mem_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  proc_valid_in,
    output logic                  proc_ready_out,
    input  logic [11:0]           proc_addr_in,
    input  logic [1:0]            proc_type_in,
    input  logic                  proc_we_in,
    input  logic [WIDTH-1:0]      proc_data_in,
    input  logic                  video_valid_in,
    output logic                  video_ready_out,
    input  logic [7:0]            video_addr_in,
    input  logic                  video_we_in,
    input  logic [WIDTH-1:0]      video_data_in,
    input  logic                  dbg_valid_in,
    output logic                  dbg_ready_out,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_in,
    input  logic                  dbg_we_in,
    input  logic [WIDTH-1:0]      dbg_data_in,
    output logic                  mem_en_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [WIDTH-1:0]      mem_data_out,
    input  logic [WIDTH-1:0]      mem_data_in,
    output logic [WIDTH-1:0]      rdata_out,
    output logic                  proc_rvalid_out,
    output logic                  video_rvalid_out,
    output logic                  dbg_rvalid_out,
    output logic                  err_out
);

    localparam logic [1:0] SRC_PROC  = 2'd0;
    localparam logic [1:0] SRC_VIDEO = 2'd1;
    localparam logic [1:0] SRC_DBG   = 2'd2;

    localparam logic [1:0] TYPE_RAM = 2'd0;
    localparam logic [1:0] TYPE_REG = 2'd1;
    localparam logic [1:0] TYPE_STK = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] VRAM_BASE = ADDR_WIDTH'(4096);
    localparam logic [ADDR_WIDTH-1:0] REG_BASE  = ADDR_WIDTH'(4352);
    localparam logic [ADDR_WIDTH-1:0] STK_BASE  = ADDR_WIDTH'(4375);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(4406);
    localparam logic [11:0]           REG_LAST  = 12'd22;
    localparam logic [11:0]           STK_LAST  = 12'd31;

    // Read tag carried down the return pipe: {is_read, illegal, src[1:0]}
    localparam int TAG_W = 4;

    // ------------------------------------------------------------------
    // Round-robin grant: scan PROC->VIDEO->DBG starting at the pointer.
    // ------------------------------------------------------------------
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] valid_vec;
    logic [2:0] scan;
    logic       gnt_any;
    logic [1:0] gnt_src;

    always_comb begin
        valid_vec = {dbg_valid_in, video_valid_in, proc_valid_in};
        gnt_any   = 1'b0;
        gnt_src   = SRC_PROC;
        scan      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            scan = {1'b0, ptr_q} + 3'(k);
            if (scan >= 3'd3) begin
                scan = scan - 3'd3;
            end
            if (!gnt_any && valid_vec[scan[1:0]]) begin
                gnt_any = 1'b1;
                gnt_src = scan[1:0];
            end
        end
    end

    // A grant only exists for a valid requester, so ready implies valid.
    assign proc_ready_out  = gnt_any && (gnt_src == SRC_PROC);
    assign video_ready_out = gnt_any && (gnt_src == SRC_VIDEO);
    assign dbg_ready_out   = gnt_any && (gnt_src == SRC_DBG);

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_src == SRC_DBG) ? SRC_PROC : gnt_src + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Translate the granted request into the flat BRAM address map.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_legal;
    logic                  req_we;
    logic [WIDTH-1:0]      req_data;

    always_comb begin
        req_addr  = dbg_addr_in;
        req_legal = (dbg_addr_in <= LAST_ADDR);
        req_we    = dbg_we_in;
        req_data  = dbg_data_in;
        case (gnt_src)
            SRC_PROC: begin
                req_we   = proc_we_in;
                req_data = proc_data_in;
                case (proc_type_in)
                    TYPE_RAM: begin
                        req_addr  = ADDR_WIDTH'(proc_addr_in);
                        req_legal = 1'b1;
                    end
                    TYPE_REG: begin
                        req_addr  = REG_BASE + ADDR_WIDTH'(proc_addr_in);
                        req_legal = (proc_addr_in <= REG_LAST);
                    end
                    TYPE_STK: begin
                        req_addr  = STK_BASE + ADDR_WIDTH'(proc_addr_in);
                        req_legal = (proc_addr_in <= STK_LAST);
                    end
                    default: begin
                        req_addr  = ADDR_WIDTH'(proc_addr_in);
                        req_legal = 1'b0;
                    end
                endcase
            end
            SRC_VIDEO: begin
                req_addr  = VRAM_BASE + ADDR_WIDTH'(video_addr_in);
                req_legal = 1'b1;
                req_we    = video_we_in;
                req_data  = video_data_in;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue stage: illegal requests are accepted but never reach the BRAM.
    // ------------------------------------------------------------------
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_data_q, mem_data_d;
    logic                  err_q, err_d;

    always_comb begin
        mem_en_d   = gnt_any && req_legal;
        mem_we_d   = gnt_any && req_legal && req_we;
        mem_addr_d = req_addr;
        mem_data_d = req_data;
        err_d      = gnt_any && !req_legal;
    end

    assign mem_en_out   = mem_en_q;
    assign mem_we_out   = mem_we_q;
    assign mem_addr_out = mem_addr_q;
    assign mem_data_out = mem_data_q;
    assign err_out      = err_q;

    // ------------------------------------------------------------------
    // Return pipe: stage 0 lines up with the issue cycle, stage RD_LATENCY
    // with the cycle the BRAM presents douta for that issue.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] tag_q [RD_LATENCY+1];
    logic [TAG_W-1:0] tag_d [RD_LATENCY+1];
    logic [TAG_W-1:0] ret_tag;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        tag_d[0] = {gnt_any && !req_we, !req_legal, gnt_src};
        for (int k = 1; k <= RD_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign ret_tag = tag_q[RD_LATENCY];

    assign proc_rvalid_out  = ret_tag[3] && (ret_tag[1:0] == SRC_PROC);
    assign video_rvalid_out = ret_tag[3] && (ret_tag[1:0] == SRC_VIDEO);
    assign dbg_rvalid_out   = ret_tag[3] && (ret_tag[1:0] == SRC_DBG);

    // douta is passed straight through on the return cycle; the flop keeps
    // the last returned value visible in between returns.
    always_comb begin
        rdata_d = rdata_q;
        if (ret_tag[3]) begin
            rdata_d = ret_tag[2] ? '0 : mem_data_in;
        end
    end

    assign rdata_out = rdata_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q      <= SRC_PROC;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

endmodule
`default_nettype wire
